// File: rtl/bus_dma_master.sv
// Bus DMA master: copies LEN bytes from SRC to DST over the shared 8-bit bus.
// Latency: 1 (REQ) + 3 per byte + 1 (DONE) cycles after START, with continuous grant.
// Backpressure: RD and WR hold their address/data until M_grant=1. M_req is held for the whole burst.
// Ports: clk/reset; S_* slave register port (SRC, DST, LEN, CTRL, STATUS);
//        M_* master bus port (req/grant, address, wr, dout, din); interrupt = DONE & INT_EN.
// Optional: define DMA_ABORT_EN for CTRL bit7 ABORT and STATUS bit2 ABORTED.
module bus_dma_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              S_sel,
  input  logic [ADDR_W-1:0] S_address,
  input  logic              S_wr,
  input  logic [DATA_W-1:0] S_din,
  output logic [DATA_W-1:0] S_dout,
  output logic              M_req,
  input  logic              M_grant,
  output logic [ADDR_W-1:0] M_address,
  output logic              M_wr,
  output logic [DATA_W-1:0] M_dout,
  input  logic [DATA_W-1:0] M_din,
  output logic              interrupt
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_RD, ST_RDW, ST_WR, ST_DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] src_reg, dst_reg, cur_src, cur_dst, addr_hold;
  logic [LEN_W-1:0]  len_reg, remain;
  logic [DATA_W-1:0] data_reg, dout_hold;
  logic              int_en, src_inc, dst_inc, done;
  logic              aborted, abort_req, abort_stop;

  logic [2:0] reg_idx;
  logic       reg_wr, busy, cfg_wr, sts_wr, start;
  logic       unused_addr;

  assign reg_idx     = S_address[2:0];
  assign unused_addr = ^S_address;
  assign reg_wr      = S_sel & S_wr;
  assign busy        = (state != ST_IDLE);
  // Configuration is frozen for the duration of a burst; STATUS W1C is not.
  assign cfg_wr      = reg_wr & ~busy;
  assign sts_wr      = reg_wr & (reg_idx == 3'd4);
  assign start       = cfg_wr & (reg_idx == 3'd3) & S_din[0];
  assign interrupt   = done & int_en;

`ifdef DMA_ABORT_EN
  logic abort_pend, abort_exit;
  assign abort_req  = reg_wr & busy & (reg_idx == 3'd3) & S_din[7];
  // An abort seen in RDW/WR must survive until the pending write is granted.
  assign abort_stop = abort_req | abort_pend;
  // Leaving a busy state for IDLE without passing through DONE means abort.
  assign abort_exit = busy & (state != ST_DONE) & (state_nx == ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abort_pend <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      abort_pend <= (abort_pend | abort_req) & (state_nx != ST_IDLE);
      if (abort_exit)
        aborted <= 1'b1;
      else if (start | (sts_wr & S_din[2]))
        aborted <= 1'b0;
    end
  end
`else
  assign abort_req  = 1'b0;
  assign abort_stop = 1'b0;
  assign aborted    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    M_req     = 1'b0;
    M_wr      = 1'b0;
    M_address = addr_hold;
    M_dout    = dout_hold;
    case (state)
      ST_IDLE: if (start && len_reg != '0) state_nx = ST_REQ;
      ST_REQ: begin
        M_req = 1'b1;
        if (abort_req)    state_nx = ST_IDLE;
        else if (M_grant) state_nx = ST_RD;
      end
      ST_RD: begin
        M_req     = 1'b1;
        M_address = cur_src;
        if (abort_req)    state_nx = ST_IDLE;
        else if (M_grant) state_nx = ST_RDW;
      end
      ST_RDW: begin
        M_req    = 1'b1;
        state_nx = ST_WR;
      end
      ST_WR: begin
        M_req     = 1'b1;
        M_wr      = 1'b1;
        M_address = cur_dst;
        M_dout    = data_reg;
        if (M_grant) begin
          if (abort_stop)                 state_nx = ST_IDLE;
          else if (remain == LEN_W'(1))   state_nx = ST_DONE;
          else                            state_nx = ST_RD;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_reg   <= '0;
      dst_reg   <= '0;
      len_reg   <= '0;
      int_en    <= 1'b0;
      src_inc   <= 1'b0;
      dst_inc   <= 1'b0;
      done      <= 1'b0;
      cur_src   <= '0;
      cur_dst   <= '0;
      remain    <= '0;
      data_reg  <= '0;
      addr_hold <= '0;
      dout_hold <= '0;
    end else begin
      if (cfg_wr) begin
        case (reg_idx)
          3'd0: src_reg <= ADDR_W'(S_din);
          3'd1: dst_reg <= ADDR_W'(S_din);
          3'd2: len_reg <= LEN_W'(S_din);
          3'd3: {dst_inc, src_inc, int_en} <= S_din[3:1];
          default: ;
        endcase
      end
      // Later assignments win: a DONE set beats a same-cycle W1C.
      if (sts_wr && S_din[1]) done <= 1'b0;
      if (start)              done <= (len_reg == '0);
      if (state == ST_DONE)   done <= 1'b1;

      if (state == ST_IDLE && start) begin
        cur_src <= src_reg;
        cur_dst <= dst_reg;
        remain  <= len_reg;
      end
      // The slave answers one cycle after the address cycle, so RDW always captures.
      if (state == ST_RDW) data_reg <= M_din;
      if (state == ST_RD)  addr_hold <= cur_src;
      if (state == ST_WR) begin
        addr_hold <= cur_dst;
        dout_hold <= data_reg;
        if (M_grant) begin
          remain  <= remain - LEN_W'(1);
          cur_src <= cur_src + ADDR_W'(src_inc);
          cur_dst <= cur_dst + ADDR_W'(dst_inc);
        end
      end
    end
  end

  always_comb begin
    S_dout = '0;
    if (S_sel) begin
      case (reg_idx)
        3'd0: S_dout = DATA_W'(src_reg);
        3'd1: S_dout = DATA_W'(dst_reg);
        3'd2: S_dout = DATA_W'(len_reg);
        3'd3: S_dout = DATA_W'({dst_inc, src_inc, int_en, 1'b0});
        3'd4: S_dout = DATA_W'({aborted, done, busy});
        default: S_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma_master.sv
module tb_bus_dma_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       S_sel, S_wr;
  logic [7:0] S_address, S_din, S_dout;
  logic       M_req, M_grant, M_wr, interrupt;
  logic [7:0] M_address, M_dout, M_din;

  bus_dma_master dut (
    .clk(clk), .reset(reset),
    .S_sel(S_sel), .S_address(S_address), .S_wr(S_wr), .S_din(S_din), .S_dout(S_dout),
    .M_req(M_req), .M_grant(M_grant), .M_address(M_address), .M_wr(M_wr),
    .M_dout(M_dout), .M_din(M_din), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [256];
  logic [15:0] wlog [$];
  logic [15:0] wexp [$];
  int checks = 0;
  int errors = 0;

  // Source slave with one-cycle read latency; the write monitor logs granted writes.
  always @(posedge clk) begin
    M_din <= mem[M_address];
    if (M_req === 1'b1 && M_grant === 1'b1 && M_wr === 1'b1)
      wlog.push_back({M_address, M_dout});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] idx, input logic [7:0] val);
    S_sel = 1'b1; S_wr = 1'b1; S_address = {5'b0, idx}; S_din = val;
    @(posedge clk); #1;
    S_sel = 1'b0; S_wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] idx, output logic [7:0] val);
    S_sel = 1'b1; S_wr = 1'b0; S_address = {5'b0, idx};
    #1 val = S_dout;
    S_sel = 1'b0;
  endtask

  // Reference: byte i goes to (dst + i*di) mod 256 carrying mem[(src + i*si) mod 256].
  task automatic build_exp(input logic [7:0] s, input logic [7:0] d, input int n,
                           input bit si, input bit di);
    wexp.delete();
    for (int i = 0; i < n; i++) begin
      int sa, da;
      sa = (s + i * si) % 256;
      da = (d + i * di) % 256;
      wexp.push_back({8'(da), mem[sa]});
    end
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_nwr"}, wlog.size(), wexp.size());
    for (int i = 0; i < wexp.size() && i < wlog.size(); i++)
      chk({tag, "_wr"}, wlog[i], wexp[i]);
  endtask

  // Polls STATUS.DONE once per cycle; optionally stalls the first WR for 5 cycles.
  task automatic wait_done(input string tag, input bit stall, output int cnt, output logic [7:0] st);
    bit stalled = 0;
    cnt = 0; st = 8'h00;
    while (cnt < 300) begin
      if (stall && !stalled && M_wr === 1'b1) begin
        int k = wlog.size();
        M_grant = 1'b0;
        repeat (5) begin
          @(posedge clk); #1; cnt++;
          chk({tag, "_hold_wr"}, M_wr, 1);
          if (k < wexp.size()) begin
            chk({tag, "_hold_addr"}, M_address, wexp[k][15:8]);
            chk({tag, "_hold_dout"}, M_dout, wexp[k][7:0]);
          end
        end
        M_grant = 1'b1;
        stalled = 1;
      end
      @(posedge clk); #1; cnt++;
      rd_reg(3'd4, st);
      if (st[1]) break;
    end
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] s, input logic [7:0] d,
                          input int n, input bit si, input bit di, input bit stall);
    int cnt;
    logic [7:0] st;
    build_exp(s, d, n, si, di);
    wlog.delete();
    wr_reg(3'd0, s);
    wr_reg(3'd1, d);
    wr_reg(3'd2, 8'(n));
    wr_reg(3'd3, {4'b0, di, si, 1'b1, 1'b1});
    wait_done(tag, stall, cnt, st);
    chk({tag, "_cycles"}, cnt, 2 + 3 * n + (stall ? 5 : 0));
    chk({tag, "_status"}, st, 8'h02);
    chk({tag, "_irq"}, interrupt, 1);
    cmp_log(tag);
    wr_reg(3'd4, 8'h02);
    chk({tag, "_irq_clr"}, interrupt, 0);
  endtask

  initial begin
    logic [7:0] v;
    int k;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hA1; mem[8'h11] = 8'hA2; mem[8'h12] = 8'hA3;
    reset = 1'b1; M_grant = 1'b1; S_sel = 1'b0; S_wr = 1'b0; S_address = 8'h00; S_din = 8'h00;
    #12;
    chk("rst_mreq", M_req, 0);
    chk("rst_mwr", M_wr, 0);
    chk("rst_maddr", M_address, 0);
    chk("rst_mdout", M_dout, 0);
    chk("rst_irq", interrupt, 0);
    rd_reg(3'd4, v); chk("rst_status", v, 0);
    rd_reg(3'd3, v); chk("rst_ctrl", v, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    run_xfer("basic", 8'h10, 8'h40, 3, 1, 1, 0);
    rd_reg(3'd4, v); chk("basic_w1c_status", v, 8'h00);
    run_xfer("fifo", 8'h00, 8'h80, 4, 0, 1, 0);
    run_xfer("stall", 8'h20, 8'h60, 3, 1, 1, 1);
    run_xfer("wrap", 8'h30, 8'hFF, 2, 1, 1, 0);
    repeat (4)
      run_xfer("rand", 8'($urandom), 8'($urandom), $urandom_range(1, 6),
               1'($urandom), 1'($urandom), 0);

    // LEN=0: DONE immediately, bus never requested.
    wr_reg(3'd2, 8'h00);
    wr_reg(3'd3, 8'h03);
    chk("len0_mreq", M_req, 0);
    rd_reg(3'd4, v); chk("len0_status", v, 8'h02);
    @(posedge clk); #1;
    chk("len0_mreq_later", M_req, 0);
    wr_reg(3'd4, 8'h02);

    // Configuration writes during a burst are dropped.
    build_exp(8'h50, 8'h70, 4, 1, 1);
    wlog.delete();
    wr_reg(3'd0, 8'h50); wr_reg(3'd1, 8'h70); wr_reg(3'd2, 8'h04); wr_reg(3'd3, 8'h0F);
    wr_reg(3'd0, 8'h99); wr_reg(3'd1, 8'h99); wr_reg(3'd2, 8'h01); wr_reg(3'd3, 8'h00);
    begin
      int cnt;
      wait_done("busycfg", 0, cnt, v);
      chk("busycfg_status", v, 8'h02);
    end
    cmp_log("busycfg");
    rd_reg(3'd0, v); chk("busycfg_src", v, 8'h50);
    rd_reg(3'd1, v); chk("busycfg_dst", v, 8'h70);
    rd_reg(3'd2, v); chk("busycfg_len", v, 8'h04);
    rd_reg(3'd3, v); chk("busycfg_ctrl", v, 8'h0E);
    wr_reg(3'd4, 8'h02);

`ifdef DMA_ABORT_EN
    // Abort in RDW of byte 2: that byte is still written, then the engine stops.
    build_exp(8'h10, 8'h90, 2, 1, 1);
    wlog.delete();
    wr_reg(3'd0, 8'h10); wr_reg(3'd1, 8'h90); wr_reg(3'd2, 8'h08); wr_reg(3'd3, 8'h0F);
    k = 0;
    while (wlog.size() < 1 && k < 50) begin @(posedge clk); #1; k++; end
    chk("abort_first_wr_seen", wlog.size(), 1);
    @(posedge clk); #1;
    wr_reg(3'd3, 8'h80);
    repeat (4) @(posedge clk);
    #1;
    cmp_log("abort");
    chk("abort_mreq", M_req, 0);
    rd_reg(3'd4, v); chk("abort_status", v, 8'h04);
    chk("abort_irq", interrupt, 0);
    wr_reg(3'd4, 8'h04);
    rd_reg(3'd4, v); chk("abort_w1c", v, 8'h00);
`endif

    // Reset in the middle of byte 2 of 4.
    wlog.delete();
    wr_reg(3'd0, 8'h10); wr_reg(3'd1, 8'h40); wr_reg(3'd2, 8'h04); wr_reg(3'd3, 8'h0F);
    k = 0;
    while (wlog.size() < 1 && k < 50) begin @(posedge clk); #1; k++; end
    chk("mid_rst_progress", wlog.size(), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_mreq", M_req, 0);
    chk("mid_rst_mwr", M_wr, 0);
    rd_reg(3'd4, v); chk("mid_rst_status", v, 8'h00);
    rd_reg(3'd0, v); chk("mid_rst_src", v, 8'h00);
    rd_reg(3'd1, v); chk("mid_rst_dst", v, 8'h00);
    rd_reg(3'd2, v); chk("mid_rst_len", v, 8'h00);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_mreq", M_req, 0);
    chk("post_rst_nwr", wlog.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
